// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcodes, FSM encoding and instruction field positions
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NEG_A = 3'b000,
    OP_NEG_B = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_MUL   = 3'b110,
    OP_XOR   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // src1 overlaps the top of the immediate; imm instructions constrain src1
  localparam int INSTR_IMM_BIT  = 15;
  localparam int INSTR_SEL_LSB  = 12;
  localparam int INSTR_DEST_LSB = 9;
  localparam int INSTR_SRC1_LSB = 6;
  localparam int INSTR_SRC2_LSB = 0;
  localparam int INSTR_IMM_LSB  = 0;

endpackage

// File: rtl/regfile_8x8.sv
// rtl/regfile_8x8.sv - 8x8 register file, two operand read ports plus debug port, r0 hardwired to zero
module regfile_8x8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] ra_addr,
  output logic [7:0] ra_data,
  input  logic [2:0] rb_addr,
  output logic [7:0] rb_data,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0][7:0] regs_q;
  logic [7:0][7:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
    regs_d[0] = 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one instruction per three cycles to an external ALU and writes back the result
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [7:0]  alu_result,
  input  logic        alu_cout,
  output logic        wb_valid,
  output logic [2:0]  wb_addr,
  output logic [7:0]  wb_data,
  output logic        carry_flag,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  state_e     state_q, state_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  alu_op_e    alu_sel_q, alu_sel_d;
  logic [2:0] dest_q, dest_d;
  logic       wb_valid_q, wb_valid_d;
  logic [2:0] wb_addr_q, wb_addr_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic       carry_q, carry_d;

  logic       rf_we;
  logic [7:0] src1_data, src2_data;

  regfile_8x8 u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra_addr  (instr[INSTR_SRC1_LSB +: 3]),
    .ra_data  (src1_data),
    .rb_addr  (instr[INSTR_SRC2_LSB +: 3]),
    .rb_data  (src2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .waddr    (dest_q),
    .wdata    (alu_result)
  );

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    dest_d     = dest_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    carry_d    = carry_q;
    rf_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          alu_sel_d = alu_op_e'(instr[INSTR_SEL_LSB +: 3]);
          dest_d    = instr[INSTR_DEST_LSB +: 3];
          alu_a_d   = src1_data;
          alu_b_d   = instr[INSTR_IMM_BIT] ? instr[INSTR_IMM_LSB +: 8] : src2_data;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rf_we      = 1'b1;
        wb_valid_d = 1'b1;
        wb_addr_d  = dest_q;
        wb_data_d  = alu_result;
        if (alu_sel_q == OP_ADD) carry_d = alu_cout;
        state_d    = ST_WB;
      end
      ST_WB: begin
        wb_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_sel_q  <= OP_NEG_A;
      dest_q     <= 3'd0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 3'd0;
      wb_data_q  <= 8'h00;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      dest_q     <= dest_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      carry_q    <= carry_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign carry_flag  = carry_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - bench for alu_issue_ctrl with external ALU model and cycle-level reference
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic [2:0]  alu_sel, wb_addr, dbg_addr;
  logic        alu_cout, wb_valid, carry_flag;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .carry_flag  (carry_flag),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu9(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (s)
      3'd0: return 9'd0 - {1'b0, a};
      3'd1: return 9'd0 - {1'b0, b};
      3'd2: return {1'b0, a} + {1'b0, b};
      3'd3: return {1'b0, a} - {1'b0, b};
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, a | b};
      3'd6: begin
        p = {8'h00, a} * {8'h00, b};
        return {|p[15:8], p[7:0]};
      end
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic logic [7:0] res8(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = alu9(s, a, b);
    return r[7:0];
  endfunction

  function automatic logic cout1(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = alu9(s, a, b);
    return r[8];
  endfunction

  assign alu_result = res8(alu_sel, alu_a, alu_b);
  assign alu_cout   = cout1(alu_sel, alu_a, alu_b);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: busy countdown since acceptance (2 = executing, 1 = writeback shown)
  logic [7:0] m_regs [8];
  logic [7:0] m_a, m_b, m_wbd;
  logic [2:0] m_sel, m_dest, m_wba;
  logic       m_wbv, m_carry;
  int         m_busy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 8'h00;
      m_a <= 8'h00; m_b <= 8'h00; m_sel <= 3'd0; m_dest <= 3'd0;
      m_wbv <= 1'b0; m_wba <= 3'd0; m_wbd <= 8'h00; m_carry <= 1'b0;
      m_busy <= 0;
    end else if (m_busy == 0) begin
      if (instr_valid) begin
        m_a    <= m_regs[instr[8:6]];
        m_b    <= instr[15] ? instr[7:0] : m_regs[instr[2:0]];
        m_sel  <= instr[14:12];
        m_dest <= instr[11:9];
        m_busy <= 2;
      end
    end else if (m_busy == 2) begin
      if (m_dest != 3'd0) m_regs[m_dest] <= res8(m_sel, m_a, m_b);
      m_wbv <= 1'b1;
      m_wba <= m_dest;
      m_wbd <= res8(m_sel, m_a, m_b);
      if (m_sel == 3'd2) m_carry <= cout1(m_sel, m_a, m_b);
      m_busy <= 1;
    end else begin
      m_wbv  <= 1'b0;
      m_busy <= 0;
    end
  end

  always @(negedge clk) begin
    chk("instr_ready", instr_ready, (m_busy == 0));
    chk("wb_valid", wb_valid, m_wbv);
    if (m_wbv) begin
      chk("wb_addr", wb_addr, m_wba);
      chk("wb_data", wb_data, m_wbd);
    end
    chk("carry_flag", carry_flag, m_carry);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_sel", alu_sel, m_sel);
    chk("dbg_data", dbg_data, m_regs[dbg_addr]);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 16'd1, 16'd0);
    tick();
    instr_valid = 1'b0;
    instr = 16'($urandom);
  endtask

  task automatic run(input logic [15:0] w);
    send(w);
    tick();
    tick();
  endtask

  task automatic peek(input logic [2:0] a, input logic [7:0] exp, input string name);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0000;
    dbg_addr = 3'd0;
    repeat (3) tick();
    chk("ready_in_reset", instr_ready, 1);
    instr_valid = 1'b1;
    tick();
    chk("no_accept_in_reset", instr_ready, 1);
    instr_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) peek(3'(i), 8'h00, "reset_reg");
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_carry", carry_flag, 0);

    // OR r1 = r0 | 0x05
    send(16'hD205);
    chk("imm_alu_a", alu_a, 8'h00);
    chk("imm_alu_b", alu_b, 8'h05);
    chk("imm_alu_sel", alu_sel, 3'b101);
    tick();
    chk("imm_wb_valid", wb_valid, 1);
    chk("imm_wb_addr", wb_addr, 1);
    chk("imm_wb_data", wb_data, 8'h05);
    tick();
    chk("imm_wb_low", wb_valid, 0);
    peek(3'd1, 8'h05, "imm_r1");

    // r1 = r3 | 0xF0 (r3 still zero), r2 = r0 | 0x20, then ADD r3 and XOR r4
    run(16'hD2F0);
    run(16'hD420);
    send(16'h2642);
    tick();
    chk("add_wb_data", wb_data, 8'h10);
    chk("add_carry", carry_flag, 1);
    tick();
    send(16'h7842);
    tick();
    chk("xor_wb_data", wb_data, 8'hD0);
    tick();
    chk("xor_carry_hold", carry_flag, 1);

    // SUB r3 = r1 - r2, then AND r5 = r3 & r1 with valid held high
    instr = 16'h3642;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin tick(); n++; end
    tick();
    instr = 16'h4AC1;
    n = 0;
    while (!instr_ready && n < 20) begin tick(); n++; end
    chk("b2b_ready_low_cycles", 16'(n), 2);
    tick();
    instr_valid = 1'b0;
    chk("b2b_alu_a", alu_a, 8'hD0);
    chk("b2b_alu_b", alu_b, 8'hF0);
    tick();
    tick();
    peek(3'd5, 8'hD0, "b2b_r5");

    // r1 = 0x05, r2 = 0x07, SUB r0 = r1 - r2
    run(16'hD205);
    run(16'hD407);
    send(16'h3042);
    tick();
    chk("r0_wb_valid", wb_valid, 1);
    chk("r0_wb_addr", wb_addr, 0);
    chk("r0_wb_data", wb_data, 8'hFE);
    tick();
    peek(3'd0, 8'h00, "r0_still_zero");

    // ADD r5 = r1 + r2 aborted by reset during EXEC
    send(16'h2A42);
    #2;
    reset_n = 1'b0;
    tick();
    chk("abort_wb_valid", wb_valid, 0);
    tick();
    peek(3'd5, 8'h00, "abort_r5");
    chk("abort_ready", instr_ready, 1);
    chk("abort_carry", carry_flag, 0);
    reset_n = 1'b1;
    tick();
    send(16'hD205);
    tick();
    chk("post_reset_wb_valid", wb_valid, 1);
    chk("post_reset_wb_data", wb_data, 8'h05);
    tick();

    for (int i = 0; i < 600; i++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      instr = 16'($urandom);
      dbg_addr = 3'($urandom);
      tick();
    end
    instr_valid = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
